user_test_engine: RTL and testbench

- PL-side register consumer sitting directly downstream of the AXI register bridge, in the user clock domain.
- Takes four control words (bridge control outputs 0..3) and runs a programmable tick generator with an LFSR pattern source.
- Returns four status words to the bridge status inputs 0..3, which software reads back.
- Control words arrive already resynchronised but may change on any cycle; commands are edge-triggered.

---
 rtl/user_test_engine.sv | 161 ++++++++++++++++
 tb/tb_user_test_engine.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/user_test_engine.sv
// user_test_engine: register-driven tick generator with a Galois LFSR
// pattern source, fed by bridge control words and reporting status words.
module user_test_engine #(
   parameter logic [15:0] VERSION   = 16'h0100,
   parameter logic [31:0] LFSR_TAPS = 32'h80200003
) (
   input  logic        user_clk,
   input  logic        user_rst_n,
   input  logic [31:0] ctrl_data0,
   input  logic [31:0] ctrl_data1,
   input  logic [31:0] ctrl_data2,
   input  logic [31:0] ctrl_data3,
   output logic [31:0] stat_data0,
   output logic [31:0] stat_data1,
   output logic [31:0] stat_data2,
   output logic [31:0] stat_data3,
   output logic        tick_o
);

   localparam logic [1:0] S_IDLE = 2'b00;
   localparam logic [1:0] S_RUN  = 2'b01;
   localparam logic [1:0] S_DONE = 2'b10;

   logic [3:0]  r_q0;
   logic [3:0]  r_qq0;
   logic [31:0] r_q1;
   logic [31:0] r_q2;
   logic [31:0] r_q3;

   logic [1:0]  r_state;
   logic        r_done;
   logic        r_abort;
   logic        r_mode;
   logic [7:0]  r_starts;
   logic [31:0] r_tick_cnt;
   logic [31:0] r_run_cnt;
   logic [31:0] r_presc;
   logic [31:0] r_period;
   logic [31:0] r_n;
   logic [31:0] r_lfsr;
   logic        r_tick;

   logic        w_start;
   logic        w_stop;
   logic        w_clear;
   logic        w_busy;
   logic        w_wrap;
   logic [31:0] w_tick_inc;
   logic [31:0] w_seed;
   logic [31:0] w_period;
   logic [31:0] w_lfsr_next;
   logic        w_unused;

   // Only the four command bits of control word 0 are meaningful.
   assign w_unused = ^ctrl_data0[31:4];

   assign w_start = r_q0[0] & ~r_qq0[0];
   assign w_stop  = r_q0[1] & ~r_qq0[1];
   assign w_clear = r_q0[2] & ~r_qq0[2];

   assign w_busy      = (r_state == S_RUN);
   assign w_wrap      = (r_presc == r_period - 32'd1);
   assign w_tick_inc  = r_tick_cnt + 32'd1;
   assign w_seed      = (r_q3 == 32'd0) ? 32'd1 : r_q3;
   assign w_period    = (r_q1 == 32'd0) ? 32'd1 : r_q1;
   assign w_lfsr_next = {1'b0, r_lfsr[31:1]}
                      ^ (r_lfsr[0] ? LFSR_TAPS : 32'd0);

   // Register control words; second stage on word 0 for edge detection.
   always_ff @(posedge user_clk or negedge user_rst_n) begin
      if (!user_rst_n) begin
         r_q0  <= '0;
         r_qq0 <= '0;
         r_q1  <= '0;
         r_q2  <= '0;
         r_q3  <= '0;
      end else begin
         r_q0  <= ctrl_data0[3:0];
         r_qq0 <= r_q0;
         r_q1  <= ctrl_data1;
         r_q2  <= ctrl_data2;
         r_q3  <= ctrl_data3;
      end
   end

   // Command handling (clear > stop > start) and the RUN tick engine.
   always_ff @(posedge user_clk or negedge user_rst_n) begin
      if (!user_rst_n) begin
         r_state    <= S_IDLE;
         r_done     <= 1'b0;
         r_abort    <= 1'b0;
         r_mode     <= 1'b0;
         r_starts   <= '0;
         r_tick_cnt <= '0;
         r_run_cnt  <= '0;
         r_presc    <= '0;
         r_period   <= 32'd1;
         r_n        <= '0;
         r_lfsr     <= 32'd1;
         r_tick     <= 1'b0;
      end else begin
         r_tick <= 1'b0;
         if (w_clear) begin
            r_state    <= S_IDLE;
            r_done     <= 1'b0;
            r_abort    <= 1'b0;
            r_starts   <= '0;
            r_tick_cnt <= '0;
            r_run_cnt  <= '0;
            r_presc    <= '0;
            r_lfsr     <= 32'd1;
         end else if (w_stop) begin
            if (r_state == S_RUN) begin
               r_state <= S_IDLE;
               r_abort <= 1'b1;
            end
         end else if (w_start && r_state != S_RUN) begin
            r_period   <= w_period;
            r_n        <= r_q2;
            r_mode     <= r_q0[3];
            r_lfsr     <= w_seed;
            r_tick_cnt <= '0;
            r_run_cnt  <= '0;
            r_presc    <= '0;
            r_abort    <= 1'b0;
            r_starts   <= r_starts + 8'd1;
            if (!r_q0[3] && r_q2 == 32'd0) begin
               r_state <= S_DONE;
               r_done  <= 1'b1;
            end else begin
               r_state <= S_RUN;
               r_done  <= 1'b0;
            end
         end else if (r_state == S_RUN) begin
            if (r_run_cnt != 32'hFFFF_FFFF) begin
               r_run_cnt <= r_run_cnt + 32'd1;
            end
            if (w_wrap) begin
               r_presc    <= '0;
               r_tick_cnt <= w_tick_inc;
               r_lfsr     <= w_lfsr_next;
               r_tick     <= 1'b1;
               if (!r_mode && w_tick_inc == r_n) begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
               end
            end else begin
               r_presc <= r_presc + 32'd1;
            end
         end
      end
   end

   assign stat_data0 = {VERSION, r_starts, 2'b00, r_state,
                        r_mode, r_abort, r_done, w_busy};
   assign stat_data1 = r_tick_cnt;
   assign stat_data2 = r_lfsr;
   assign stat_data3 = r_run_cnt;
   assign tick_o     = r_tick;

endmodule

// File: tb/tb_user_test_engine.sv
// tb_user_test_engine: table, randomized and hand-written sequences
// against a transaction-level model of user_test_engine.
module tb_user_test_engine;

   localparam logic [31:0] TAPS = 32'h80200003;

   logic        clk;
   logic        rst_n;
   logic [31:0] ctrl_data0, ctrl_data1, ctrl_data2, ctrl_data3;
   logic [31:0] stat_data0, stat_data1, stat_data2, stat_data3;
   logic        tick_o;

   int n_tests = 0;
   int n_fail  = 0;
   int starts  = 0;

   user_test_engine dut (
      .user_clk   (clk),
      .user_rst_n (rst_n),
      .ctrl_data0 (ctrl_data0),
      .ctrl_data1 (ctrl_data1),
      .ctrl_data2 (ctrl_data2),
      .ctrl_data3 (ctrl_data3),
      .stat_data0 (stat_data0),
      .stat_data1 (stat_data1),
      .stat_data2 (stat_data2),
      .stat_data3 (stat_data3),
      .tick_o     (tick_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] p;
      logic [31:0] n;
      logic [31:0] seed;
      logic [31:0] e_ticks;
      logic [31:0] e_run;
      logic [31:0] e_lfsr;
   } vec_t;

   vec_t tbl[5];

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference LFSR: apply the Galois rule 'steps' times from the seed.
   function automatic logic [31:0] lfsr_model(input logic [31:0] seed,
                                              input int steps);
      logic [31:0] x;
      x = (seed == 0) ? 32'd1 : seed;
      for (int i = 0; i < steps; i++)
         x = (x >> 1) ^ (x[0] ? TAPS : 32'd0);
      return x;
   endfunction

   function automatic logic [31:0] stat0_exp(input logic [7:0] low);
      logic [7:0] s;
      s = 8'(starts);
      return {16'h0100, s, low};
   endfunction

   // One one-shot run: program, start, wait for DONE, check everything.
   task automatic run_oneshot(input logic [31:0] p, input logic [31:0] n,
                              input logic [31:0] seed,
                              input logic [31:0] e_ticks,
                              input logic [31:0] e_run,
                              input logic [31:0] e_lfsr,
                              input string tag);
      int pulses, cyc, last, peff;
      bit gap_ok, fin;
      @(negedge clk);
      ctrl_data0 = 0;
      ctrl_data1 = p;
      ctrl_data2 = n;
      ctrl_data3 = seed;
      repeat (2) @(negedge clk);
      ctrl_data0 = 32'h1;
      starts++;
      pulses = 0; cyc = 0; last = -1; gap_ok = 1; fin = 0;
      peff = (p == 0) ? 1 : int'(p);
      repeat (2) begin
         @(negedge clk);
         cyc++;
         if (tick_o) pulses++;
      end
      check({tag, " latency state"}, 32'(stat_data0[5:4]),
            (n == 0) ? 32'd2 : 32'd1);
      while (!fin && cyc < 2000) begin
         @(negedge clk);
         cyc++;
         if (tick_o) begin
            if (last >= 0 && cyc - last != peff) gap_ok = 0;
            last = cyc;
            pulses++;
         end
         if (stat_data0[5:4] == 2'b10) fin = 1;
      end
      repeat (3) begin
         @(negedge clk);
         if (tick_o) pulses++;
      end
      check({tag, " reached DONE"}, 32'(fin), 32'd1);
      check({tag, " tick pulses"}, pulses, e_ticks);
      check({tag, " tick spacing"}, 32'(gap_ok), 32'd1);
      check({tag, " stat0"}, stat_data0, stat0_exp(8'h22));
      check({tag, " stat1"}, stat_data1, e_ticks);
      check({tag, " stat2"}, stat_data2, e_lfsr);
      check({tag, " stat3"}, stat_data3, e_run);
      ctrl_data0 = 0;
   endtask

   initial begin
      int pulses, cyc, ticks_seen;
      logic [31:0] rp, rn, rs;
      bit found;

      tbl[0] = '{32'd4, 32'd3, 32'd1, 32'd3, 32'd12, 32'h60180001};
      tbl[1] = '{32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'h80200003};
      tbl[2] = '{32'd0, 32'd2, 32'd2, 32'd2, 32'd2, 32'h80200003};
      tbl[3] = '{32'd2, 32'd0, 32'd0, 32'd0, 32'd0, 32'h00000001};
      tbl[4] = '{32'd3, 32'd1, 32'h80000000, 32'd1, 32'd3, 32'h40000000};

      rst_n = 1'b0;
      ctrl_data0 = 0; ctrl_data1 = 0; ctrl_data2 = 0; ctrl_data3 = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Idle after reset: no false edges, reset values held.
      ticks_seen = 0;
      repeat (20) begin
         @(negedge clk);
         if (tick_o) ticks_seen++;
      end
      check("reset tick_o", ticks_seen, 0);
      check("reset stat0", stat_data0, 32'h01000000);
      check("reset stat1", stat_data1, 32'd0);
      check("reset stat2", stat_data2, 32'd1);
      check("reset stat3", stat_data3, 32'd0);

      for (int i = 0; i < 5; i++)
         run_oneshot(tbl[i].p, tbl[i].n, tbl[i].seed, tbl[i].e_ticks,
                     tbl[i].e_run, tbl[i].e_lfsr, $sformatf("vec%0d", i));

      for (int i = 0; i < 6; i++) begin
         rp = $urandom_range(0, 5);
         rn = $urandom_range(0, 6);
         rs = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
         run_oneshot(rp, rn, rs, rn, rn * ((rp == 0) ? 32'd1 : rp),
                     lfsr_model(rs, int'(rn)), $sformatf("rnd%0d", i));
      end

      // Continuous mode, P=0: tick every cycle, stop after 10 ticks.
      @(negedge clk);
      ctrl_data1 = 0; ctrl_data3 = 32'h5; ctrl_data0 = 32'h8;
      repeat (2) @(negedge clk);
      ctrl_data0 = 32'h9;
      starts++;
      pulses = 0; cyc = 0;
      while (pulses < 10 && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (tick_o) pulses++;
      end
      ctrl_data0 = 32'hB;
      do begin
         @(negedge clk);
         cyc++;
         if (tick_o) pulses++;
      end while (stat_data0[5:4] != 2'b00 && cyc < 200);
      check("cont stopped in time", 32'(cyc < 200), 32'd1);
      check("cont stat0", stat_data0, stat0_exp(8'h0C));
      check("cont stat1", stat_data1, pulses);
      check("cont stat2", stat_data2, lfsr_model(32'h5, pulses));
      check("cont stat3", stat_data3, pulses);
      ctrl_data0 = 32'h9;
      ticks_seen = 0;
      repeat (2) @(negedge clk);
      ctrl_data0 = 32'hB;
      repeat (3) begin
         @(negedge clk);
         if (tick_o) ticks_seen++;
      end
      check("second stop ticks", ticks_seen, 0);
      check("second stop stat0", stat_data0, stat0_exp(8'h0C));
      check("second stop stat1", stat_data1, pulses);

      // Clear alone, then a level-held start and a start during RUN.
      ctrl_data0 = 0;
      repeat (2) @(negedge clk);
      ctrl_data0 = 32'h4;
      repeat (3) @(negedge clk);
      starts = 0;
      check("clear stat0", stat_data0 & 32'hFFFF_FFF7, 32'h01000000);
      check("clear stat1", stat_data1, 32'd0);
      check("clear stat2", stat_data2, 32'd1);
      check("clear stat3", stat_data3, 32'd0);
      ctrl_data0 = 0;
      ctrl_data1 = 1000; ctrl_data2 = 5; ctrl_data3 = 7;
      repeat (2) @(negedge clk);
      ctrl_data0 = 32'h1;
      repeat (50) @(negedge clk);
      starts++;
      check("held start count", 32'(stat_data0[15:8]), starts);
      check("held start state", 32'(stat_data0[5:4]), 32'd1);
      ctrl_data0 = 0;
      repeat (2) @(negedge clk);
      ctrl_data0 = 32'h1;
      repeat (3) @(negedge clk);
      check("run restart count", 32'(stat_data0[15:8]), starts);
      check("run restart state", 32'(stat_data0[5:4]), 32'd1);

      // Clear and start rising together: clear wins.
      ctrl_data0 = 0;
      repeat (2) @(negedge clk);
      ctrl_data0 = 32'h5;
      repeat (3) @(negedge clk);
      starts = 0;
      check("clr+start stat0", stat_data0, stat0_exp(8'h00));
      check("clr+start stat1", stat_data1, 32'd0);
      check("clr+start stat2", stat_data2, 32'd1);
      check("clr+start stat3", stat_data3, 32'd0);

      // Reset mid-RUN while tick_o is high.
      ctrl_data0 = 0;
      ctrl_data1 = 3; ctrl_data3 = 9;
      repeat (2) @(negedge clk);
      ctrl_data0 = 32'h9;
      found = 0; cyc = 0;
      while (!found && cyc < 50) begin
         @(negedge clk);
         cyc++;
         if (tick_o) found = 1;
      end
      check("mid-run tick seen", 32'(found), 32'd1);
      rst_n = 1'b0;
      #1;
      check("async rst tick_o", 32'(tick_o), 32'd0);
      check("async rst stat0", stat_data0, 32'h01000000);
      check("async rst stat1", stat_data1, 32'd0);
      check("async rst stat2", stat_data2, 32'd1);
      check("async rst stat3", stat_data3, 32'd0);
      ctrl_data0 = 0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
